multi_blinker: RTL
==================

Name: multi_blinker

Overview:
- Multi-channel successor to the single-channel blink counter: N_CH independent LED/indicator enables, each with runtime-programmable on/off lengths and a per-channel mode (off, solid, blink, burst).
- Shared prescaler generates a time-base tick; all channel counters advance only on that tick.
- Sits between the display/status control logic and the LED drivers.

Parameters:
- N_CH, 4, number of channels.
- C_BITS, 8, width of per-channel on/off length fields, counted in ticks.
- PRESCALE, 50000, clocks per tick. Legal range is ≥1; 1 means a tick on every clock.
- PS_BITS, 16, prescaler counter width. Must satisfy 2^PS_BITS ≥ PRESCALE.
- BURST_BITS, 3, width of the per-channel burst pulse count.
- GAP_TICKS, 16, gap length in ticks after each burst. Shared by all channels; legal range is ≥1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  reset, asynchronous, active-low.
- mode  input  2*N_CH  per-channel mode, channel i at [2i+1:2i]: 00 off, 01 solid, 10 blink, 11 burst.
- on_len  input  C_BITS*N_CH  per-channel on length in ticks.
- off_len  input  C_BITS*N_CH  per-channel off length in ticks.
- burst_cnt  input  BURST_BITS*N_CH  per-channel pulses per burst.
- b_en  output  N_CH  registered enable per channel.
- phase_start  output  N_CH  one-clock pulse when a channel enters its ON phase in blink or burst mode.
- tick  output  1  one-clock prescaler tick, for debug and synchronisation.

Behaviour:
- Reset (reset=0, asynchronous): prescaler=0; all channels in IDLE with counters 0; b_en=0, phase_start=0, tick=0.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - tick=1 for the single clock in which the count equals PRESCALE-1; the tick output is registered.
  - Free-running, independent of mode.
- Per-channel FSM states: IDLE, SOLID, ON, OFF, GAP. b_en=1 in SOLID and ON only.
- Mode sampling: mode is sampled every clock. A mode value differing from the channel's previous sampled mode forces a restart on the next clock edge:
  - 00 → IDLE.
  - 01 → SOLID.
  - 10 or 11 → ON, with phase_start=1, counter loaded from on_len, and the burst pulse counter loaded from burst_cnt.
- Latency: b_en and phase_start change on the clock edge after the mode change is seen (1 clock). They do not wait for a tick.
- Length sampling:
  - on_len and off_len are latched at phase entry; changes mid-phase take effect at the next phase.
  - A length of 0 is treated as 1.
- Phase counting: the counter decrements on each tick. A phase ends on the tick where the counter reaches 1, so ON lasts exactly max(on_len,1) ticks. If phase entry is not tick-aligned, the first tick period is partial.
- Blink: ON → OFF → ON … indefinitely; phase_start pulses at every ON entry.
- Burst:
  - ON → OFF repeats burst_cnt times; the burst pulse counter decrements at each ON exit.
  - After the last ON, the channel enters GAP instead of OFF. GAP lasts GAP_TICKS ticks, then returns to ON with burst_cnt reloaded.
  - burst_cnt=0 is treated as 1.
- Simultaneous events:
  - A mode change on the same clock as a tick: the mode change wins and the tick is ignored for that channel.
  - Every channel reaching its phase end on the same tick is legal; channels are fully independent.
- Reset mid-operation: all channels go to IDLE immediately (asynchronous). After release, channels restart from mode on the first clock; a non-00 mode produces a phase_start.
- No arithmetic overflow: counters are C_BITS or BURST_BITS wide, load only from inputs, and never decrement below 1.

Optional Feature:
- Macro: MULTI_BLINKER_BURST_EN.
- Defined: burst mode (11) behaves as described above, including the GAP state and burst counters.
- Undefined: GAP state, burst counters and burst_cnt usage are removed. Mode 11 behaves identically to mode 10 (blink). The burst_cnt port remains present but is ignored.

Test Plan:
- Reset hold: reset=0 with mode=01 on all channels → b_en=0, tick=0. On release → b_en=4'b1111 one clock after the first sampled edge.
- Blink, PRESCALE=2, ch0 mode=10, on_len=3, off_len=2 →
  - b_en[0] high 6 clocks, low 4 clocks, repeating.
  - phase_start[0] pulses at every rising edge of b_en[0].
- Zero lengths, PRESCALE=1, on_len=0, off_len=0 → b_en toggles every clock.
- Burst, PRESCALE=1, burst_cnt=2, on=1, off=1, GAP_TICKS=3 → b_en pattern 1,0,1,0,0,0,1,… With the macro undefined → plain 1,0,1,0,… pattern.
- Mid-phase change: on_len changed 3→5 during ON → current ON stays 3 ticks and the next ON lasts 5. Switching mode 10→01 mid-OFF → b_en=1 on the next clock.
- Asynchronous reset mid-burst (non-clock-aligned) → b_en cleared immediately. After release with mode=11 → phase_start pulses and the burst restarts from a full count.

Source files
------------

// File: rtl/multi_blinker.sv
// multi_blinker: N_CH independent LED enables sharing one prescaled time base.
// Each channel runs its own off / solid / blink / burst sequencer with
// runtime on/off lengths latched at phase entry.
// Build option: define MULTI_BLINKER_BURST_EN to enable burst mode (11) with the
// GAP state and burst counters; otherwise mode 11 behaves as blink and burst_cnt
// is ignored.
module multi_blinker #(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned C_BITS     = 8,
    parameter int unsigned PRESCALE   = 50000,
    parameter int unsigned PS_BITS    = 16,
    parameter int unsigned BURST_BITS = 3,
    parameter int unsigned GAP_TICKS  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [2*N_CH-1:0]          mode,
    input  logic [C_BITS*N_CH-1:0]     on_len,
    input  logic [C_BITS*N_CH-1:0]     off_len,
    input  logic [BURST_BITS*N_CH-1:0] burst_cnt,
    output logic [N_CH-1:0]            b_en,
    output logic [N_CH-1:0]            phase_start,
    output logic                       tick
);

    localparam logic [PS_BITS-1:0] PS_LAST = PS_BITS'(PRESCALE - 1);

`ifdef MULTI_BLINKER_BURST_EN
    // The phase counter also times the gap, so it must hold GAP_TICKS.
    localparam int unsigned GAP_W = $clog2(GAP_TICKS + 1);
    localparam int unsigned CNT_W = (C_BITS > GAP_W) ? C_BITS : GAP_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SOLID = 3'd1,
        ST_ON    = 3'd2,
        ST_OFF   = 3'd3,
        ST_GAP   = 3'd4
    } state_t;
`else
    localparam int unsigned CNT_W = C_BITS;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SOLID = 3'd1,
        ST_ON    = 3'd2,
        ST_OFF   = 3'd3
    } state_t;

    // Burst inputs are kept on the port list for drop-in compatibility only.
    logic unused_cfg;
    assign unused_cfg = ^{burst_cnt, 32'(GAP_TICKS)};
`endif

    // Phase length load value: a zero length behaves as one tick.
    function automatic logic [CNT_W-1:0] len_ld(input logic [C_BITS-1:0] len);
        len_ld = (len == '0) ? CNT_W'(1) : CNT_W'(len);
    endfunction

    logic [PS_BITS-1:0] ps_cnt;
    logic [PS_BITS-1:0] ps_next;

    // Prescaler next count: 0..PRESCALE-1 then wrap.
    always_comb begin
        ps_next = ps_cnt + PS_BITS'(1);
        if (ps_cnt == PS_LAST) begin
            ps_next = '0;
        end
    end

    // Prescaler register; tick is high for the cycle in which the count sits at PRESCALE-1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ps_cnt <= '0;
            tick   <= 1'b0;
        end else begin
            ps_cnt <= ps_next;
            tick   <= (ps_next == PS_LAST);
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [1:0]       mode_cur;
        logic [1:0]       mode_q;
        logic             restart;
        logic             cnt_last;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic [CNT_W-1:0] on_ld;
        logic [CNT_W-1:0] off_ld;
        state_t           state_q;
        state_t           state_d;
        logic             b_en_q;
        logic             b_en_d;
        logic             pstart_q;
        logic             pstart_d;
`ifdef MULTI_BLINKER_BURST_EN
        logic [BURST_BITS-1:0] bc_q;
        logic [BURST_BITS-1:0] bc_d;
        logic [BURST_BITS-1:0] bc_ld;
        logic                  burst_mode;

        assign bc_ld = (burst_cnt[i*BURST_BITS +: BURST_BITS] == '0) ?
                       BURST_BITS'(1) : burst_cnt[i*BURST_BITS +: BURST_BITS];
        assign burst_mode = (mode_q == 2'b11);
`endif

        assign mode_cur = mode[2*i +: 2];
        assign on_ld    = len_ld(on_len[i*C_BITS +: C_BITS]);
        assign off_ld   = len_ld(off_len[i*C_BITS +: C_BITS]);
        assign restart  = (mode_cur != mode_q);
        assign cnt_last = (cnt_q == CNT_W'(1));

        // Channel state register with registered outputs.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q  <= ST_IDLE;
                mode_q   <= 2'b00;
                cnt_q    <= '0;
                b_en_q   <= 1'b0;
                pstart_q <= 1'b0;
`ifdef MULTI_BLINKER_BURST_EN
                bc_q     <= '0;
`endif
            end else begin
                state_q  <= state_d;
                mode_q   <= mode_cur;
                cnt_q    <= cnt_d;
                b_en_q   <= b_en_d;
                pstart_q <= pstart_d;
`ifdef MULTI_BLINKER_BURST_EN
                bc_q     <= bc_d;
`endif
            end
        end

        // Next state: a mode change restarts the channel and overrides any tick.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
`ifdef MULTI_BLINKER_BURST_EN
            bc_d    = bc_q;
`endif
            if (restart) begin
                cnt_d = '0;
`ifdef MULTI_BLINKER_BURST_EN
                bc_d  = '0;
`endif
                case (mode_cur)
                    2'b00: state_d = ST_IDLE;
                    2'b01: state_d = ST_SOLID;
                    default: begin
                        state_d = ST_ON;
                        cnt_d   = on_ld;
`ifdef MULTI_BLINKER_BURST_EN
                        bc_d    = bc_ld;
`endif
                    end
                endcase
            end else if (tick) begin
                case (state_q)
                    ST_ON: begin
                        if (cnt_last) begin
`ifdef MULTI_BLINKER_BURST_EN
                            if (burst_mode && (bc_q == BURST_BITS'(1))) begin
                                state_d = ST_GAP;
                                cnt_d   = CNT_W'(GAP_TICKS);
                            end else begin
                                if (burst_mode) begin
                                    bc_d = bc_q - BURST_BITS'(1);
                                end
                                state_d = ST_OFF;
                                cnt_d   = off_ld;
                            end
`else
                            state_d = ST_OFF;
                            cnt_d   = off_ld;
`endif
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                    ST_OFF: begin
                        if (cnt_last) begin
                            state_d = ST_ON;
                            cnt_d   = on_ld;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
`ifdef MULTI_BLINKER_BURST_EN
                    ST_GAP: begin
                        if (cnt_last) begin
                            state_d = ST_ON;
                            cnt_d   = on_ld;
                            bc_d    = bc_ld;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
`endif
                    default: begin
                    end
                endcase
            end
        end

        // Output decode: enable in SOLID/ON, pulse on every entry into ON.
        always_comb begin
            b_en_d   = 1'b0;
            pstart_d = 1'b0;
            if ((state_d == ST_SOLID) || (state_d == ST_ON)) begin
                b_en_d = 1'b1;
            end
            if ((state_d == ST_ON) && (restart || (state_q != ST_ON))) begin
                pstart_d = 1'b1;
            end
        end

        assign b_en[i]        = b_en_q;
        assign phase_start[i] = pstart_q;
    end

endmodule
